// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 4x4 weight-stationary systolic array.
// Latches weights, streams activation vectors through a row skew, then
// deskews the bottom-row column outputs into one aligned result vector.
// Optional cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.

// Per-lane delay line: DEPTH registers, cleared by reset.
module systolic_ctrl_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] stg_q, stg_d;

  // shift the lane one stage per cycle
  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stg_d[i] = stg_q[i-1];
  end

  // stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  assign q = stg_q[DEPTH-1];
endmodule

module systolic_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ACCUMULATE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              len,
  input  logic [16*WIDTH-1:0]     w_in,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [4*WIDTH-1:0]      act_data,
  output logic                    arr_load,
  output logic [16*WIDTH-1:0]     arr_weights,
  output logic [WIDTH-1:0]        arr_row0,
  output logic [WIDTH-1:0]        arr_row1,
  output logic [WIDTH-1:0]        arr_row2,
  output logic [WIDTH-1:0]        arr_row3,
  input  logic [4*ACCUMULATE-1:0] arr_result,
  output logic                    res_valid,
  output logic [4*ACCUMULATE-1:0] res_data,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             perf_cycles
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [16*WIDTH-1:0]   wts_q, wts_d;
  logic [7:0]            vld_q, vld_d;   // accept -> result latency tracker
  logic                  done_q, done_d; // zero-length job completion
  logic                  accept;

  logic [3:0][WIDTH-1:0]      lane_in, row;
  logic [3:0][ACCUMULATE-1:0] col_out;

  assign accept = (state_q == S_STREAM) && act_valid;

  // next state, job bookkeeping and valid pipeline
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wts_d   = wts_q;
    done_d  = 1'b0;
    vld_d   = {vld_q[6:0], accept};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != 8'd0) begin
            wts_d   = w_in;
            len_d   = len;
            cnt_d   = 8'd0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_STREAM;
      S_STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_q == 8'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      wts_q   <= '0;
      vld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wts_q   <= wts_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign act_ready   = (state_q == S_STREAM);
  assign arr_load    = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign arr_weights = wts_q;
  assign res_valid   = vld_q[7];
  // drain completes in the cycle right after the last result leaves
  assign done        = done_q | ((state_q == S_DRAIN) && (vld_q == 8'd0));

  // lane r skewed by r+1 registers; column c deskewed by 3-c registers
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_in[i] = accept ? act_data[i*WIDTH +: WIDTH] : '0;
    systolic_ctrl_dly #(.W(WIDTH), .DEPTH(i+1)) u_skew (
      .clk(clk), .reset(reset), .d(lane_in[i]), .q(row[i])
    );
    if (i == 3) begin : g_pass
      assign col_out[i] = arr_result[i*ACCUMULATE +: ACCUMULATE];
    end else begin : g_dsk
      systolic_ctrl_dly #(.W(ACCUMULATE), .DEPTH(3-i)) u_dsk (
        .clk(clk), .reset(reset),
        .d(arr_result[i*ACCUMULATE +: ACCUMULATE]), .q(col_out[i])
      );
    end
  end

  assign arr_row0 = row[0];
  assign arr_row1 = row[1];
  assign arr_row2 = row[2];
  assign arr_row3 = row[3];
  // column 3 is a straight wire, so gate to keep data quiet between results
  assign res_data = res_valid ? col_out : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // job cycle counter: cleared on start, counts busy cycles, holds when idle
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) perf_d = 32'd0;
    else if (busy)                    perf_d = perf_q + 32'd1;
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioral skewed 4x4 array model on the array
// side, scoreboard of expected result vectors and their arrival cycles.
module tb_systolic_ctrl;
  localparam int W = 8;
  localparam int A = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    len;
  logic [127:0]  w_in;
  logic          act_valid;
  logic          act_ready;
  logic [31:0]   act_data;
  logic          arr_load;
  logic [127:0]  arr_weights;
  logic [7:0]    arr_row0, arr_row1, arr_row2, arr_row3;
  logic [127:0]  arr_result;
  logic          res_valid;
  logic [127:0]  res_data;
  logic          busy, done;
  logic [31:0]   perf_cycles;

  systolic_ctrl #(.WIDTH(W), .ACCUMULATE(A)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_in(w_in),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .arr_load(arr_load), .arr_weights(arr_weights),
    .arr_row0(arr_row0), .arr_row1(arr_row1), .arr_row2(arr_row2), .arr_row3(arr_row3),
    .arr_result(arr_result), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- array model: row r reaches column c's bottom output 4+c-r cycles later
  logic [3:0][7:0] rows_w;
  logic [3:0][7:0] ahist [1:7];
  assign rows_w = {arr_row3, arr_row2, arr_row1, arr_row0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 1; d <= 7; d++) ahist[d] <= '0;
    end else begin
      ahist[1] <= rows_w;
      for (int d = 2; d <= 7; d++) ahist[d] <= ahist[d-1];
    end
  end

  always_comb begin
    logic [31:0] s;
    s = '0;
    arr_result = '0;
    for (int c = 0; c < 4; c++) begin
      s = '0;
      for (int r = 0; r < 4; r++)
        s = s + 32'(ahist[4+c-r][r]) * 32'(arr_weights[(4*r+c)*8 +: 8]);
      arr_result[c*32 +: 32] = s;
    end
  end

  // ---- scoreboard
  typedef struct { logic [127:0] data; int cyc; } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  logic [127:0] w_cur;
  logic [31:0]  hist [0:3];
  int          load_cnt = 0, res_cnt = 0, done_cnt = 0;
  int          done_cyc = 0, last_res_cyc = 0;
  logic [127:0] last_res = '0;

  function automatic logic [127:0] exp_res(input logic [31:0] a, input logic [127:0] w);
    logic [127:0] v;
    logic [31:0]  s;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      s = '0;
      for (int r = 0; r < 4; r++) s = s + 32'(a[r*8 +: 8]) * 32'(w[(4*r+c)*8 +: 8]);
      v[c*32 +: 32] = s;
    end
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      for (int i = 0; i < 4; i++) hist[i] = '0;
    end else begin
      for (int r = 0; r < 4; r++)
        chk($sformatf("row%0d", r), 128'(rows_w[r]), 128'(hist[r][r*8 +: 8]));
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = (act_valid && act_ready) ? act_data : 32'd0;
      if (act_valid && act_ready) sb.push_back('{exp_res(act_data, w_cur), cyc + 8});
      if (res_valid) begin
        res_cnt++;
        last_res_cyc = cyc;
        last_res = res_data;
        if (sb.size() == 0) chk("res_spurious", 128'(1), 128'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_cycle", 128'(cyc), 128'(e.cyc));
          chk("res_data", res_data, e.data);
        end
      end else begin
        chk("res_data_idle", res_data, '0);
      end
      if (arr_load) load_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // ---- stimulus
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!act_ready && n < 20) begin step(); n++; end
    if (!act_ready) chk("ready_timeout", 128'(0), 128'(1));
  endtask

  task automatic run_job(input logic [127:0] w, input logic [7:0] n, input int gap,
                         input logic [31:0] d0);
    int dc, k;
    dc = done_cnt;
    w_in = w; w_cur = w; len = n; start = 1'b1;
    step();
    start = 1'b0;
    wait_ready();
    for (int i = 0; i < int'(n); i++) begin
      act_valid = 1'b1;
      act_data  = (i == 0) ? d0 : $urandom;
      step();
      act_valid = 1'b0;
      if (i < int'(n) - 1) repeat (gap) step();
    end
    // restart attempt and new weights while draining must be ignored
    w_in = ~w; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (done_cnt == dc && k < 40) begin step(); k++; end
    if (done_cnt == dc) chk("done_timeout", 128'(0), 128'(1));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] wid, wr;
    int l0, r0, d0;
    reset = 1'b0; start = 1'b0; len = '0; w_in = '0; act_valid = 1'b0; act_data = '0;
    w_cur = '0;
    #12;
    chk("rst_busy", 128'(busy), '0);
    chk("rst_done", 128'(done), '0);
    chk("rst_load", 128'(arr_load), '0);
    chk("rst_ready", 128'(act_ready), '0);
    chk("rst_resv", 128'(res_valid), '0);
    chk("rst_resd", res_data, '0);
    chk("rst_rows", 128'(rows_w), '0);
    chk("rst_wts", arr_weights, '0);
    chk("rst_perf", 128'(perf_cycles), '0);
    step();
    reset = 1'b1;
    step();

    // identity weights, single vector {1,2,3,4}
    wid = '0;
    for (int r = 0; r < 4; r++) wid[(4*r+r)*8 +: 8] = 8'd1;
    l0 = load_cnt; r0 = res_cnt; d0 = done_cnt;
    run_job(wid, 8'd1, 0, 32'h04030201);
    chk("j1_loads", 128'(load_cnt - l0), 128'(1));
    chk("j1_results", 128'(res_cnt - r0), 128'(1));
    chk("j1_dones", 128'(done_cnt - d0), 128'(1));
    chk("j1_value", last_res, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("j1_done_cyc", 128'(done_cyc), 128'(last_res_cyc + 1));
    chk("j1_idle", 128'(busy), '0);

    // len=4, act_valid held high, random weights
    wr = {$urandom, $urandom, $urandom, $urandom};
    r0 = res_cnt;
    run_job(wr, 8'd4, 0, $urandom);
    chk("j2_results", 128'(res_cnt - r0), 128'(4));
    chk("j2_done_cyc", 128'(done_cyc), 128'(last_res_cyc + 1));

    // len=3 with two bubble cycles between vectors
    wr = {$urandom, $urandom, $urandom, $urandom};
    r0 = res_cnt;
    run_job(wr, 8'd3, 2, $urandom);
    chk("j3_results", 128'(res_cnt - r0), 128'(3));
    chk("j3_done_cyc", 128'(done_cyc), 128'(last_res_cyc + 1));

    // zero-length job
    l0 = load_cnt; d0 = done_cnt;
    len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_done", 128'(done), 128'(1));
    chk("len0_busy", 128'(busy), '0);
    step();
    chk("len0_done_off", 128'(done), '0);
    chk("len0_busy2", 128'(busy), '0);
    chk("len0_dones", 128'(done_cnt - d0), 128'(1));
    chk("len0_loads", 128'(load_cnt - l0), '0);

    // len=2 back to back: cycle counter
    wr = {$urandom, $urandom, $urandom, $urandom};
    run_job(wr, 8'd2, 0, $urandom);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("perf_len2", 128'(perf_cycles), 128'(12));
`else
    chk("perf_tied", 128'(perf_cycles), '0);
`endif

    // reset in the middle of streaming
    d0 = done_cnt;
    w_in = {$urandom, $urandom, $urandom, $urandom}; w_cur = w_in;
    len = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_ready();
    act_valid = 1'b1; act_data = $urandom;
    step();
    #2 reset = 1'b0;
    #1;
    chk("mid_busy", 128'(busy), '0);
    chk("mid_done", 128'(done), '0);
    chk("mid_ready", 128'(act_ready), '0);
    chk("mid_load", 128'(arr_load), '0);
    chk("mid_resv", 128'(res_valid), '0);
    chk("mid_resd", res_data, '0);
    chk("mid_rows", 128'(rows_w), '0);
    chk("mid_wts", arr_weights, '0);
    chk("mid_perf", 128'(perf_cycles), '0);
    act_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_no_done", 128'(done_cnt - d0), '0);
    r0 = res_cnt;
    run_job(wid, 8'd1, 0, 32'h0a0b0c0d);
    chk("post_results", 128'(res_cnt - r0), 128'(1));
    chk("post_value", last_res, {32'h0a, 32'h0b, 32'h0c, 32'h0d});
    chk("post_dones", 128'(done_cnt - d0), 128'(1));

    repeat (3) step();
    chk("sb_empty", 128'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width of array rows and weights.
REQ-002 SHALL have parameter ACCUMULATE, default 32, partial-sum/result width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  begin job; accepted only in IDLE.
REQ-006 SHALL have port len  in  8  number of activation vectors in job.
REQ-007 SHALL have port w_in  in  16*WIDTH  weights, row-major, element [r][c] at bits (4r+c)*WIDTH.
REQ-008 SHALL have ports act_valid/act_ready  in/out  1/1  activation handshake.
REQ-009 SHALL have port act_data  in  4*WIDTH  activation vector, lane r drives array row r.
REQ-010 SHALL have ports arr_load, arr_weights, arr_row0..3  out  1, 16*WIDTH, WIDTH each  array drive.
REQ-011 SHALL have port arr_result  in  4*ACCUMULATE  bottom-row south outputs, lane c = column c.
REQ-012 SHALL have ports res_valid, res_data  out  1, 4*ACCUMULATE  deskewed result vector.
REQ-013 SHALL have ports busy, done  out  1, 1  job active; one-cycle completion pulse.
REQ-014 SHALL have port perf_cycles  out  32  job cycle count (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> STREAM -> DRAIN -> IDLE.
REQ-016 IDLE: start=1 and len!=0 SHALL latch w_in into arr_weights, latch len, go LOAD; start with len=0 SHALL pulse done next cycle, stay IDLE.
REQ-017 LOAD: SHALL assert arr_load exactly one cycle, then go STREAM.
REQ-018 STREAM: act_ready SHALL be 1; a vector is accepted when act_valid&act_ready; after len accepts go DRAIN.
REQ-019 Row skew: lane r of accepted vector SHALL appear on arr_row r exactly r+1 cycles after accept (lane 0 one register, lane 3 four).
REQ-020 Cycles without accept (bubble) SHALL inject zero into skew lane 0 input; bubbles SHALL NOT produce res_valid.
REQ-021 Deskew: column c of arr_result SHALL be delayed 3-c cycles so all four lanes align.
REQ-022 res_valid SHALL assert exactly 8 cycles after each accept, one cycle per accepted vector, in order, via an 8-deep valid shift register.
REQ-023 DRAIN: SHALL persist until the valid shift register is empty, then pulse done one cycle, go IDLE.
REQ-024 busy SHALL be 1 in LOAD, STREAM, DRAIN; 0 in IDLE.
REQ-025 start while busy SHALL be ignored; w_in changes while busy SHALL NOT affect arr_weights.
REQ-026 No result backpressure: res_data SHALL be valid only while res_valid=1.
REQ-027 act_ready SHALL be 0 outside STREAM.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE and clear skew/deskew/valid registers, counters, arr_weights.
REQ-029 During reset: arr_load, act_ready, res_valid, busy, done, arr_row0..3, res_data, perf_cycles SHALL be 0.
REQ-030 Reset mid-job SHALL abort with no done pulse; first post-reset job SHALL behave as from power-up.

Configuration
REQ-031 Macro SYSTOLIC_CTRL_PERF_EN: when defined, perf_cycles SHALL clear on start acceptance, increment each cycle while busy, hold after done.
REQ-032 Without SYSTOLIC_CTRL_PERF_EN, perf_cycles SHALL be tied to 0 and the counter SHALL not exist.

Verification
REQ-033 Identity weights, len=1, act_data lanes {1,2,3,4} -> arr_load one pulse, res_valid 8 cycles after accept, res_data {1,2,3,4}.
REQ-034 len=4, act_valid held 1 -> four consecutive res_valid cycles, done one cycle after last res_valid.
REQ-035 len=3, act_valid low two cycles between vectors -> exactly 3 res_valid pulses, gaps matching input gaps.
REQ-036 len=0 start -> done pulse next cycle, busy stays 0, no arr_load.
REQ-037 reset low mid-STREAM -> all outputs 0 same cycle, no done; new job len=1 then completes normally.
REQ-038 With SYSTOLIC_CTRL_PERF_EN, len=2 back-to-back -> perf_cycles=12 after done.
